// File: rtl/simd_pkg.sv
// rtl/simd_pkg.sv - shared opcodes, size defaults and FSM states for the SIMD sequencer
package simd_pkg;

  localparam int NLANES_DEF = 10;
  localparam int DW_DEF     = 16;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_MAX = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    READ = 2'b01,
    EXEC = 2'b10,
    DONE = 2'b11
  } state_t;

endpackage

// File: rtl/simd_lane_alu.sv
// rtl/simd_lane_alu.sv - combinational per-lane arithmetic (add, unsigned max, xor)
module simd_lane_alu
  import simd_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [1:0]    op,
  output logic [DW-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_ADD:  y = a + b;
      OP_MAX:  y = (a >= b) ? a : b;  // ties pick A
      OP_XOR:  y = a ^ b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/simd_seq_ctrl.sv
// rtl/simd_seq_ctrl.sv - lane sequencer: reads one memory line per lane, runs the ALU,
// and hands results out through a single valid/ready output register
module simd_seq_ctrl
  import simd_pkg::*;
#(
  parameter int NLANES = NLANES_DEF,
  parameter int DW     = DW_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [3:0]      count,
  input  logic [1:0]      opcode,
  input  logic            abort,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic            mem_rd_en,
  output logic [3:0]      mem_addr,
  input  logic [2*DW-1:0] mem_rdata,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [3:0]      res_idx,
  output logic [DW-1:0]   res_data
);

  localparam logic [3:0] NL = 4'(NLANES);

  state_t          state, state_nx;
  logic [3:0]      idx, cnt_q;
  logic [1:0]      op_q;
  logic            err_q, rd_q;
  logic [2*DW-1:0] opnd_q, opnd;
  logic [DW-1:0]   alu_y;
  logic            legal, commit, last;

  assign legal  = (count != 4'd0) && (count <= NL) && (opcode != OP_ILL);
  // Read data is only on the bus in the first EXEC cycle; a stalled EXEC uses the copy.
  assign opnd   = rd_q ? mem_rdata : opnd_q;
  assign commit = (state == EXEC) && (!res_valid || res_ready) && !abort;
  assign last   = (idx == cnt_q);

  simd_lane_alu #(.DW(DW)) u_alu (
    .a  (opnd[2*DW-1:DW]),
    .b  (opnd[DW-1:0]),
    .op (op_q),
    .y  (alu_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = legal ? READ : DONE;
      READ: state_nx = abort ? IDLE : EXEC;
      EXEC: begin
        if (abort)       state_nx = IDLE;
        else if (commit) state_nx = last ? DONE : READ;
      end
      DONE: if (abort || !res_valid) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    mem_rd_en = (state == READ);
    mem_addr  = (state == READ) ? idx : 4'd0;
    done      = (state == DONE) && !res_valid && !abort;
    err       = done && err_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= 4'd1;
      cnt_q     <= 4'd0;
      op_q      <= OP_ADD;
      err_q     <= 1'b0;
      rd_q      <= 1'b0;
      opnd_q    <= '0;
      res_valid <= 1'b0;
      res_idx   <= 4'd0;
      res_data  <= '0;
    end else begin
      rd_q <= (state == READ) && !abort;
      if (state == EXEC) opnd_q <= opnd;
      if (state == IDLE && start) begin
        err_q <= !legal;
        if (legal) begin
          cnt_q <= count;
          op_q  <= opcode;
          idx   <= 4'd1;
        end
      end
      if (commit && !last) idx <= idx + 4'd1;
      if (busy && abort) begin
        res_valid <= 1'b0;
      end else if (commit) begin
        res_valid <= 1'b1;
        res_idx   <= idx;
        res_data  <= alu_y;
      end else if (res_valid && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_simd_seq_ctrl.sv
// tb/tb_simd_seq_ctrl.sv - scoreboard bench for simd_seq_ctrl
module tb_simd_seq_ctrl;
  import simd_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, start, abort, res_ready;
  logic [3:0]  count;
  logic [1:0]  opcode;
  logic        busy, done, err, mem_rd_en, res_valid;
  logic [3:0]  mem_addr, res_idx;
  logic [31:0] mem_rdata;
  logic [15:0] res_data;

  logic [31:0] mem [0:15];
  logic [19:0] exp_q[$];
  logic [19:0] e;
  int n_tests = 0, n_fail = 0;
  int done_cnt = 0, err_cnt = 0, rd_cnt = 0, cyc = 0, first_rd = -1, last_acc = 0;
  int d0, e0, r0;

  always #5 clk = ~clk;

  simd_seq_ctrl #(.NLANES(10), .DW(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .count(count), .opcode(opcode),
    .abort(abort), .busy(busy), .done(done), .err(err), .mem_rd_en(mem_rd_en),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .res_valid(res_valid),
    .res_ready(res_ready), .res_idx(res_idx), .res_data(res_data)
  );

  always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_op(input logic [1:0] op, input logic [31:0] line);
    logic [15:0] a, b;
    a = line[31:16];
    b = line[15:0];
    case (op)
      2'b00:   return 16'((32'(a) + 32'(b)) & 32'h0000_FFFF);
      2'b01:   return (b > a) ? b : a;
      default: return a ^ b;
    endcase
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (done) done_cnt++;
      if (err) err_cnt++;
      if (mem_rd_en) begin
        rd_cnt++;
        if (first_rd < 0) first_rd = cyc;
      end
      if (res_valid && res_ready) begin
        last_acc = cyc;
        if (exp_q.size() == 0) begin
          check("unexpected_result", {12'h0, res_idx, res_data}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("result", {12'h0, res_idx, res_data}, {12'h0, e});
        end
      end
    end
  end

  task automatic push_exp(input logic [1:0] op, input int n);
    for (int i = 1; i <= n; i++) exp_q.push_back({4'(i), ref_op(op, mem[i])});
  endtask

  task automatic start_cmd(input logic [1:0] op, input logic [3:0] n);
    @(posedge clk); #1;
    start = 1'b1; opcode = op; count = n;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
    if (!ok) check("timeout_idle", {31'h0, busy}, 32'h0);
  endtask

  task automatic wait_rd(input logic [3:0] a);
    bit ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (mem_rd_en && mem_addr == a) begin ok = 1'b1; break; end
    end
    if (!ok) check("timeout_rd", {28'h0, mem_addr}, {28'h0, a});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; res_ready = 1'b1;
    count = 4'd0; opcode = OP_ADD;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    #12;
    check("reset_outputs", {3'h0, busy, done, err, mem_rd_en, res_valid, mem_addr, res_idx, res_data}, 32'h0);
    @(negedge clk); rst_n = 1'b1;

    // add, 3 lanes
    mem[1] = 32'h0005_0003; mem[2] = 32'hFFFF_0002; mem[3] = 32'h1234_0000;
    exp_q.push_back({4'd1, 16'h0008});
    exp_q.push_back({4'd2, 16'h0001});
    exp_q.push_back({4'd3, 16'h1234});
    d0 = done_cnt; first_rd = -1;
    start_cmd(OP_ADD, 4'd3);
    wait_idle();
    check("add_done_once", done_cnt - d0, 1);
    check("add_rd_to_last", last_acc - first_rd, 6);
    check("add_drained", exp_q.size(), 0);

    // max and xor on the same lines
    mem[1] = 32'h8000_7FFF; mem[2] = 32'h0010_0010;
    exp_q.push_back({4'd1, 16'h8000});
    exp_q.push_back({4'd2, 16'h0010});
    start_cmd(OP_MAX, 4'd2);
    wait_idle();
    exp_q.push_back({4'd1, 16'hFFFF});
    exp_q.push_back({4'd2, 16'h0000});
    start_cmd(OP_XOR, 4'd2);
    wait_idle();
    check("maxxor_drained", exp_q.size(), 0);

    // rejected commands
    for (int k = 0; k < 3; k++) begin
      r0 = rd_cnt; e0 = err_cnt;
      case (k)
        0:       start_cmd(OP_ILL, 4'd3);
        1:       start_cmd(OP_ADD, 4'd0);
        default: start_cmd(OP_ADD, 4'd11);
      endcase
      @(negedge clk);
      check("illegal_done_err", {30'h0, done, err}, 32'h3);
      wait_idle();
      check("illegal_no_read", rd_cnt - r0, 0);
      check("illegal_err_once", err_cnt - e0, 1);
    end

    // 10 lanes with a backpressure hold
    for (int i = 1; i <= 10; i++) mem[i] = $urandom;
    push_exp(OP_ADD, 10);
    d0 = done_cnt;
    start_cmd(OP_ADD, 4'd10);
    wait_rd(4'd3);
    @(posedge clk); #1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    for (int h = 0; h < 5; h++) begin
      @(negedge clk);
      check("stall_hold", {11'h0, res_valid, res_idx, res_data}, {11'h0, 1'b1, 4'd3, ref_op(OP_ADD, mem[3])});
      if (h > 0) check("stall_no_read", {31'h0, mem_rd_en}, 32'h0);
    end
    @(posedge clk); #1;
    res_ready = 1'b1;
    wait_idle();
    check("long_drained", exp_q.size(), 0);
    check("long_done_once", done_cnt - d0, 1);

    // abort during EXEC of lane 2
    for (int i = 1; i <= 5; i++) mem[i] = $urandom;
    push_exp(OP_XOR, 1);
    d0 = done_cnt; e0 = err_cnt;
    start_cmd(OP_XOR, 4'd5);
    wait_rd(4'd2);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    check("abort_idle", {30'h0, busy, res_valid}, 32'h0);
    repeat (4) @(negedge clk);
    check("abort_no_done", done_cnt - d0 + err_cnt - e0, 0);
    check("abort_no_commit", exp_q.size(), 0);
    push_exp(OP_XOR, 2);
    start_cmd(OP_XOR, 4'd2);
    wait_idle();
    check("after_abort_drained", exp_q.size(), 0);

    // asynchronous reset mid-command, then immediate restart
    for (int i = 1; i <= 10; i++) mem[i] = $urandom;
    push_exp(OP_ADD, 10);
    start_cmd(OP_ADD, 4'd10);
    repeat (6) @(negedge clk);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("async_reset", {3'h0, busy, done, err, mem_rd_en, res_valid, mem_addr, res_idx, res_data}, 32'h0);
    exp_q.delete();
    push_exp(OP_MAX, 3);
    start = 1'b1; opcode = OP_MAX; count = 4'd3;
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("start_after_reset", {31'h0, busy}, 32'h1);
    d0 = done_cnt; e0 = err_cnt;
    @(posedge clk); #1;
    start = 1'b1; opcode = OP_ILL; count = 4'd0;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle();
    repeat (2) @(negedge clk);
    check("busy_start_ignored_err", err_cnt - e0, 0);
    check("busy_start_done_once", done_cnt - d0, 1);
    check("reset_run_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/simd_seq_ctrl.md
SIMD_SEQ_CTRL -- requirements
Module: simd_seq_ctrl

Interface
REQ-001 Parameter: NLANES, default 10, number of memory lines / SIMD lanes; lanes are numbered 1..NLANES.
REQ-002 Parameter: DW, default 16, operand and result width; each memory line is 2*DW bits wide.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  command strobe; sampled only in IDLE.
REQ-006 count  input  4  number of lanes to process, lanes 1..count; sampled with start.
REQ-007 opcode  input  2  operation, sampled with start: 00 = add, 01 = unsigned max, 10 = xor, 11 = illegal.
REQ-008 abort  input  1  cancels the running command.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 done  output  1  one-cycle pulse marking the end of a command.
REQ-011 err  output  1  one-cycle pulse, coincident with done, marking a rejected command.
REQ-012 mem_rd_en  output  1  memory read strobe.
REQ-013 mem_addr  output  4  line address (1..NLANES).
REQ-014 mem_rdata  input  2*DW  line read data, valid exactly one cycle after mem_rd_en; operand A = [2*DW-1:DW], operand B = [DW-1:0].
REQ-015 res_valid  output  1  result-valid flag.
REQ-016 res_ready  input  1  consumer ready.
REQ-017 res_idx  output  4  lane number of the result.
REQ-018 res_data  output  DW  lane result.

Function
REQ-019 FSM states SHALL be IDLE, READ, EXEC and DONE.
REQ-020 IDLE -> READ SHALL occur on start with 1 <= count <= NLANES and opcode != 11; this latches count and opcode and sets lane index idx = 1.
REQ-021 IDLE -> DONE SHALL occur on start with count = 0, count > NLANES or opcode = 11; err is pulsed and no memory read is issued.
REQ-022 READ SHALL assert mem_rd_en = 1 and mem_addr = idx for exactly one cycle, then go to EXEC.
REQ-023 EXEC SHALL compute result = f(A, B) from mem_rdata using the latched opcode.
  - add: wraps modulo 2^DW.
  - max: unsigned compare; A is selected when A = B.
  - xor: bitwise A ^ B.
REQ-024 The EXEC commit edge SHALL occur only when the output register is free (!res_valid || res_ready).
  - At that edge: res_valid <= 1, res_idx <= idx, res_data <= result.
  - Otherwise EXEC holds, with the captured operands held internally.
REQ-025 At the EXEC commit edge, if idx == count the FSM SHALL go to DONE; otherwise idx increments and the FSM goes to READ. Throughput is 2 cycles per lane when unstalled.
REQ-026 res_valid SHALL clear on the edge where res_valid && res_ready, unless a new commit occurs on that same edge; a new commit overwrites the register.
REQ-027 res_idx/res_data SHALL remain stable while res_valid && !res_ready.
REQ-028 DONE SHALL pulse done for one cycle and return to IDLE.
  - For a legal command, DONE is left only once the last result has been accepted; done is asserted in the cycle res_valid clears.
REQ-029 start SHALL be ignored while busy.
REQ-030 abort in READ, EXEC or DONE SHALL force IDLE on the next edge, clear res_valid, and suppress done/err; abort in IDLE has no effect.
REQ-031 An abort coinciding with a commit edge SHALL take priority; no result is committed.

Reset
REQ-032 On rst_n low, asynchronously: state = IDLE; idx = 1; busy, done, err, mem_rd_en, res_valid = 0; mem_addr, res_idx, res_data = 0.
REQ-033 Reset asserted mid-command SHALL discard the command entirely; after release, the block accepts start on the first rising edge.

Structure
REQ-034 A shared package simd_pkg SHALL hold:
  - the opcode encodings (OP_ADD, OP_MAX, OP_XOR, OP_ILL);
  - NLANES and DW defaults;
  - the FSM state enumeration.
REQ-035 The lane arithmetic SHALL be a combinational sub-module simd_lane_alu (inputs a, b, op; output y); the FSM, index counter and output register live in simd_seq_ctrl.

Verification
REQ-036 Add, count = 3, memory lines 1..3 = {0x0005, 0x0003}, {0xFFFF, 0x0002}, {0x1234, 0x0000}, res_ready = 1 -> results (1, 0x0008), (2, 0x0001), (3, 0x1234); done pulses once; 6 mem_rd_en-to-commit cycles.
REQ-037 Max, count = 2, lines {0x8000, 0x7FFF}, {0x0010, 0x0010} -> (1, 0x8000), (2, 0x0010); xor on the same lines -> (1, 0xFFFF), (2, 0x0000).
REQ-038 opcode = 11, or count = 0, or count = 11 -> no mem_rd_en; done and err pulse together 1 cycle after start.
REQ-039 count = 10 with res_ready held low for 5 cycles at lane 4 -> res_idx/res_data stable while held, no mem_rd_en for lane 5 until acceptance, all 10 results delivered in order.
REQ-040 abort during EXEC of lane 2 of 5 -> busy low next cycle, res_valid low, no done; a new start then runs normally from lane 1.
REQ-041 rst_n low for 1 cycle mid-command (asynchronous, between edges) -> outputs at reset values immediately; start repeated during busy is ignored.
